// File: rtl/branch_redirect_unit.sv
// Branch-target adder and PC-redirect controller for EX: resolves taken jumps/branches,
// holds a valid/ready redirect towards IF, flags misaligned targets and counts accepted redirects.
module branch_redirect_unit #(
  parameter int RV32C = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_EX,
  input  logic             is_jump_EX,
  input  logic             is_jalr_EX,
  input  logic             is_branch_EX,
  input  logic             branch_decision_EX,
  input  logic [31:0]      bt_a_operand_i,
  input  logic [31:0]      bt_b_operand_i,
  input  logic             flush_i,
  input  logic             redirect_ready_i,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic             ex_stall_o,
  output logic             flush_id_o,
  output logic             exc_misaligned_o,
  output logic [31:0]      exc_tval_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t           r_state, w_stateNext;
  logic [31:0]      w_sum, w_target;
  logic             w_taken, w_misaligned;
  logic             w_capture, w_raiseExc, w_accept;
  logic [31:0]      r_redirectPc, r_excTval;
  logic             r_excPulse;
  logic [CNT_W-1:0] r_cnt;

  assign w_sum        = bt_a_operand_i + bt_b_operand_i;
  assign w_target     = {w_sum[31:1], w_sum[0] & ~is_jalr_EX};
  assign w_taken      = valid_EX & (is_jump_EX | (is_branch_EX & branch_decision_EX));
  assign w_misaligned = w_taken & (((RV32C == 0) & w_target[1]) | w_target[0]);

  // While PEND, anything in EX is wrong-path and is ignored; flush_i beats ready.
  always_comb begin
    w_stateNext = r_state;
    w_capture   = 1'b0;
    w_raiseExc  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flush_i && w_taken) begin
          if (w_misaligned) begin
            w_raiseExc = 1'b1;
          end else begin
            w_capture   = 1'b1;
            w_stateNext = PEND;
          end
        end
      end
      PEND: begin
        if (flush_i) begin
          w_stateNext = IDLE;
        end else if (redirect_ready_i) begin
          w_accept    = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_redirectPc <= '0;
      r_excTval    <= '0;
      r_excPulse   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_excPulse <= w_raiseExc;
      if (w_capture) r_redirectPc <= w_target;
      if (w_raiseExc) r_excTval <= w_target;
      if (w_accept && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign redirect_valid_o = (r_state == PEND);
  assign ex_stall_o       = (r_state == PEND);
  assign redirect_pc_o    = r_redirectPc;
  assign flush_id_o       = w_accept & ~rst_i;
  assign exc_misaligned_o = r_excPulse;
  assign exc_tval_o       = r_excTval;
  assign redirect_cnt_o   = r_cnt;

endmodule
